// File: rtl/sipo_pkg.sv
// Shared types for the SIPO receiver: FSM state encoding and parity-sense constants.
`timescale 1ns/1ps
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } sipo_state_e;

  localparam logic SIPO_PAR_EVEN = 1'b0;
  localparam logic SIPO_PAR_ODD  = 1'b1;

endpackage

// File: rtl/sipo_hold_reg.sv
// WIDTH-bit output holding register with valid/ready and overrun detection.
// Handshake: a word transfers on any edge where vld_o & rdy_i; vld_o never drops without it.
`timescale 1ns/1ps
module sipo_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             rdy_i,
  output logic [WIDTH-1:0] data_o,
  output logic             vld_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             accept;
  logic             can_load;

  always_comb begin
    accept   = vld_q & rdy_i;
    // A draining word frees the slot in the same cycle a new one arrives.
    can_load = ~vld_q | accept;
    data_d   = data_q;
    vld_d    = vld_q & ~accept;
    ovr_d    = 1'b0;
    if (load_i) begin
      if (can_load) begin
        data_d = word_i;
        vld_d  = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign vld_o     = vld_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: LSB-first frames into WIDTH-bit words behind a valid/ready register.
// Optional trailing parity bit per frame when SIPO_PARITY_EN is defined.
`timescale 1ns/1ps
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_i,
  input  logic             bit_vld_i,
  input  logic             sof_i,
  output logic [WIDTH-1:0] data_o,
  output logic             data_vld_o,
  input  logic             data_rdy_i,
  output logic             overrun_o,
  output logic             frame_err_o,
  output logic             parity_err_o
);

  localparam int              CW        = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_IDX  = CW'(WIDTH - 1);
  localparam logic            PAR_SENSE = PARITY_ODD ? SIPO_PAR_ODD : SIPO_PAR_EVEN;

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             frame_err_q, frame_err_d;
  logic             parity_err_q, parity_err_d;
  logic             word_vld;
  logic [WIDTH-1:0] word;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    word_vld     = 1'b0;
    word         = shift_q;
    if (bit_vld_i) begin
      if (sof_i) begin
        // sof restarts the frame from any state; only mid-frame is an error.
        frame_err_d = (state_q != ST_IDLE);
        shift_d     = '0;
        shift_d[0]  = serial_i;
        cnt_d       = CW'(1);
        state_d     = ST_SHIFT;
      end else begin
        case (state_q)
          ST_SHIFT: begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt_q == CW'(i)) shift_d[i] = serial_i;
            end
            if (cnt_q == LAST_IDX) begin
`ifdef SIPO_PARITY_EN
              cnt_d   = cnt_q + CW'(1);
              state_d = ST_PARITY;
`else
              word     = shift_d;
              word_vld = 1'b1;
              cnt_d    = '0;
              state_d  = ST_IDLE;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef SIPO_PARITY_EN
          ST_PARITY: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            if ((^shift_q ^ serial_i) == PAR_SENSE) word_vld = 1'b1;
            else                                    parity_err_d = 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

`ifndef SIPO_PARITY_EN
  logic unused_par_sense;
  assign unused_par_sense = PAR_SENSE;
`endif

  sipo_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load_i    (word_vld),
    .word_i    (word),
    .rdy_i     (data_rdy_i),
    .data_o    (data_o),
    .vld_o     (data_vld_o),
    .overrun_o (overrun_o)
  );

  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: frame-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_sipo_rx;

  localparam int   W      = 4;
  localparam logic PAR_ODD = 1'b0;
`ifdef SIPO_PARITY_EN
  localparam int   FRAME_LEN = W + 1;
`else
  localparam int   FRAME_LEN = W;
`endif

  logic         clk;
  logic         reset;
  logic         serial_i;
  logic         bit_vld_i;
  logic         sof_i;
  logic [W-1:0] data_o;
  logic         data_vld_o;
  logic         data_rdy_i;
  logic         overrun_o;
  logic         frame_err_o;
  logic         parity_err_o;

  int checks = 0;
  int errors = 0;

  sipo_rx #(.WIDTH(W), .PARITY_ODD(PAR_ODD)) dut (
    .clk          (clk),
    .reset        (reset),
    .serial_i     (serial_i),
    .bit_vld_i    (bit_vld_i),
    .sof_i        (sof_i),
    .data_o       (data_o),
    .data_vld_o   (data_vld_o),
    .data_rdy_i   (data_rdy_i),
    .overrun_o    (overrun_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: partial frame as a bit queue, holding register as exp_q
  logic         m_bits[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_data = '0;
  logic         m_ovr = 1'b0;
  logic         m_fe  = 1'b0;
  logic         m_pe  = 1'b0;

  always @(posedge clk or posedge reset) begin
    logic [W-1:0] w;
    logic         par;
    if (reset) begin
      m_bits.delete();
      exp_q.delete();
      m_data = '0;
      m_ovr  = 1'b0;
      m_fe   = 1'b0;
      m_pe   = 1'b0;
    end else begin
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_pe  = 1'b0;
      if (exp_q.size() != 0 && data_rdy_i) void'(exp_q.pop_front());
      if (bit_vld_i) begin
        if (sof_i) begin
          m_fe = (m_bits.size() != 0);
          m_bits.delete();
          m_bits.push_back(serial_i);
        end else if (m_bits.size() != 0) begin
          m_bits.push_back(serial_i);
        end
        if (m_bits.size() == FRAME_LEN) begin
          w   = '0;
          par = 1'b0;
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (i < W) w[i] = m_bits[i];
            par = par ^ m_bits[i];
          end
`ifdef SIPO_PARITY_EN
          if (par != PAR_ODD) m_pe = 1'b1;
`endif
          if (!m_pe) begin
            if (exp_q.size() == 0) begin
              exp_q.push_back(w);
              m_data = w;
            end else begin
              m_ovr = 1'b1;
            end
          end
          m_bits.delete();
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (!reset) begin
      check("m_vld",  {31'd0, data_vld_o},   {31'd0, exp_q.size() != 0});
      check("m_data", {28'd0, data_o},       {28'd0, m_data});
      check("m_ovr",  {31'd0, overrun_o},    {31'd0, m_ovr});
      check("m_fe",   {31'd0, frame_err_o},  {31'd0, m_fe});
      check("m_pe",   {31'd0, parity_err_o}, {31'd0, m_pe});
    end
  end

  // driver tasks: each starts and ends 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic sof);
    serial_i  = b;
    sof_i     = sof;
    bit_vld_i = 1'b1;
    @(posedge clk);
    #1;
    bit_vld_i = 1'b0;
    sof_i     = 1'b0;
    serial_i  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic bad_par, input int gap,
                            input int rdy_last);
    logic b;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < W) b = w[i];
      else       b = (^w) ^ PAR_ODD ^ bad_par;
      if (i == FRAME_LEN - 1 && rdy_last >= 0) data_rdy_i = rdy_last[0];
      send_bit(b, i == 0);
      if (i != FRAME_LEN - 1) idle(gap);
    end
  endtask

  initial begin
    reset      = 1'b1;
    serial_i   = 1'b0;
    bit_vld_i  = 1'b0;
    sof_i      = 1'b0;
    data_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {28'd0, data_o}, 32'h0);
    check("rst_vld",  {31'd0, data_vld_o}, 32'h0);
    check("rst_errs", {29'd0, overrun_o, frame_err_o, parity_err_o}, 32'h0);
    reset = 1'b0;
    idle(2);

    // basic frame 1,0,1,1 -> 4'hD
    data_rdy_i = 1'b1;
    send_frame(4'hD, 1'b0, 0, -1);
    check("t1_vld",  {31'd0, data_vld_o}, 32'h1);
    check("t1_data", {28'd0, data_o}, 32'hD);
    idle(1);
    check("t1_drain", {31'd0, data_vld_o}, 32'h0);

    // stray bits ignored, then gapped frame
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("t2_stray", {31'd0, data_vld_o}, 32'h0);
    send_frame(4'hD, 1'b0, 3, -1);
    check("t2_data", {28'd0, data_o}, 32'hD);
    idle(2);

    // overrun with consumer stalled
    data_rdy_i = 1'b0;
    send_frame(4'h5, 1'b0, 0, -1);
    send_frame(4'hA, 1'b0, 0, -1);
    check("t3_ovr",  {31'd0, overrun_o}, 32'h1);
    check("t3_data", {28'd0, data_o}, 32'h5);
    idle(1);
    check("t3_ovr_pulse", {31'd0, overrun_o}, 32'h0);
    data_rdy_i = 1'b1;
    idle(1);
    check("t3_drain", {31'd0, data_vld_o}, 32'h0);

    // accept and load in the same cycle
    data_rdy_i = 1'b0;
    send_frame(4'h5, 1'b0, 0, -1);
    send_frame(4'hA, 1'b0, 0, 1);
    check("t4_data", {28'd0, data_o}, 32'hA);
    check("t4_vld",  {31'd0, data_vld_o}, 32'h1);
    check("t4_ovr",  {31'd0, overrun_o}, 32'h0);
    idle(1);

    // sof mid-frame
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    check("t5_fe", {31'd0, frame_err_o}, 32'h1);
    for (int i = 1; i < FRAME_LEN; i++) begin
      logic [W-1:0] v;
      v = 4'h3;
      send_bit(i < W ? v[i] : ((^v) ^ PAR_ODD), 1'b0);
    end
    check("t5_data", {28'd0, data_o}, 32'h3);

    // async reset mid-frame with a word held
    data_rdy_i = 1'b0;
    send_frame(4'h9, 1'b0, 0, -1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    reset = 1'b1;
    #2;
    check("t5_rst_data", {28'd0, data_o}, 32'h0);
    check("t5_rst_vld",  {31'd0, data_vld_o}, 32'h0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < FRAME_LEN; i++) send_bit(1'b1, 1'b0);
    check("t5_nosof", {31'd0, data_vld_o}, 32'h0);
    send_frame(4'h6, 1'b0, 1, -1);
    check("t5_after", {28'd0, data_o}, 32'h6);
    data_rdy_i = 1'b1;
    idle(2);

`ifdef SIPO_PARITY_EN
    send_frame(4'hD, 1'b0, 0, -1);
    check("t6_good", {28'd0, data_o}, 32'hD);
    idle(1);
    send_frame(4'hD, 1'b1, 0, -1);
    check("t6_pe",  {31'd0, parity_err_o}, 32'h1);
    check("t6_vld", {31'd0, data_vld_o}, 32'h0);
    idle(1);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      serial_i   = 1'($urandom_range(0, 1));
      bit_vld_i  = ($urandom_range(0, 3) != 0);
      sof_i      = ($urandom_range(0, 7) == 0);
      data_rdy_i = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    bit_vld_i = 1'b0;
    sof_i     = 1'b0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
